// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// parity/majority helpers (the parity helper is also used by the transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 7;

  // Parity bit a transmitter appends to make the frame even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte delivery bus: one-entry valid/ready holding register plus
// the error flags that travel with each byte.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Multi-flop metastability synchronizer with a configurable reset value
// (idle-high for UART lines).
module sync_2ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer, 16x oversampled, 8N1/8E1/8O1 with valid/ready hold.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting (cnt 6/7/8, decision at 8).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  logic      rx,
  input  logic      parity_en,
  input  logic      parity_odd,
  output logic      busy,
  uart_rx_if.master bus
);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SP = 4'(SAMPLE_POINT + 1);
`else
  localparam logic [3:0] SP = 4'(SAMPLE_POINT);
`endif
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]           smp_q, smp_d;
`endif

  logic rx_s;
  logic bit_val;
  logic at_sample;
  logic at_wrap;

  sync_2ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      smp_q   <= '1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_MAJORITY_EN
      smp_q   <= smp_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    perr_d    = perr_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    ovr_d     = 1'b0;
    valid_d   = valid_q & ~bus.rx_ready;
    at_sample = tick && (cnt_q == SP);
    at_wrap   = tick && (cnt_q == LAST_TICK);
`ifdef UART_RX_MAJORITY_EN
    smp_d = smp_q;
    if (tick && cnt_q == 4'd6) smp_d[0] = rx_s;
    if (tick && cnt_q == 4'd7) smp_d[1] = rx_s;
    bit_val = maj3(smp_q[0], smp_q[1], rx_s);
`else
    bit_val = rx_s;
`endif

    if (tick && state_q != IDLE) cnt_d = cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          idx_d   = '0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (at_sample && bit_val) state_d = IDLE;
        else if (at_wrap)         state_d = DATA;
      end
      DATA: begin
        if (at_sample) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (idx_q == LAST_IDX) state_d = parity_en ? PARITY : STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (at_sample) perr_d = (bit_val != parity_bit(8'(shift_q), parity_odd));
        if (at_wrap)   state_d = STOP;
      end
      STOP: begin
        // Frame completes at the stop-bit centre; a held byte not being
        // accepted this clk means the new frame is dropped as an overrun.
        if (at_sample) begin
          if (!valid_q || bus.rx_ready) begin
            data_d  = shift_q;
            fe_d    = ~bit_val;
            pe_d    = parity_en & perr_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = bit_val ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = fe_q;
  assign bus.parity_err  = pe_q;
  assign bus.overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are built bit by bit from a
// byte-level model and the delivered byte/flags are compared against it.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic busy;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int unsigned tcnt = 0;
  always @(negedge clk) begin
    tcnt = tcnt + 1;
    tick = (tcnt % 4 == 0);
  end

  int total = 0;
  int bad = 0;

  localparam int BIT_CLKS = 64;

  typedef struct {
    bit         rose;
    int         rise_at;
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         ovr;
    logic       valid_after;
  } obs_t;

  // Reference: the parity bit a correct transmitter would send.
  function automatic logic good_pbit(input logic [7:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return 1'(ones % 2) ^ odd;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, optional parity, then the stop bit
  // while watching the delivery side for a new byte or an overrun pulse.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb, output obs_t o);
    logic prev;
    o.rose = 0; o.rise_at = -1; o.data = '0; o.fe = 0; o.pe = 0; o.ovr = 0;
    o.valid_after = 1'bx;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    rx = stopb;
    prev = bus.rx_valid;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge clk);
      if (o.rose && o.rise_at == i - 1) o.valid_after = bus.rx_valid;
      if (!prev && bus.rx_valid && !o.rose) begin
        o.rose = 1; o.rise_at = i;
        o.data = bus.rx_data; o.fe = bus.frame_err; o.pe = bus.parity_err;
      end
      if (bus.overrun_err) o.ovr++;
      prev = bus.rx_valid;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", bus.frame_err); end
    total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_pe: got %b want 0", bus.parity_err); end
    total++; if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.overrun_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    idle(20);
  endtask

  task automatic test_basic;
    obs_t o;
    bus.rx_ready = 1'b1; parity_en = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, o);
    total++; if (o.rose !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", o.rose); end
    // Stop-bit centre is ~32 clks into the stop bit, plus sync/detect delay.
    total++; if (o.rise_at < 28 || o.rise_at > 52) begin bad++; $display("FAIL basic_latency: got %0d want 28..52", o.rise_at); end
    total++; if (o.data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", o.data); end
    total++; if (o.fe !== 1'b0) begin bad++; $display("FAIL basic_fe: got %b want 0", o.fe); end
    total++; if (o.pe !== 1'b0) begin bad++; $display("FAIL basic_pe: got %b want 0", o.pe); end
    total++; if (o.valid_after !== 1'b0) begin bad++; $display("FAIL basic_accept_drop: got %b want 0", o.valid_after); end
    idle(32);
  endtask

  task automatic test_parity;
    obs_t o;
    logic [7:0] d;
    logic [1:0] odd_v, pb_v;
    bus.rx_ready = 1'b1; parity_en = 1'b1;
    odd_v = 2'b10; pb_v = 2'b01;
    for (int k = 0; k < 3; k++) begin
      d = 8'h03;
      parity_odd = (k == 2) ? 1'b1 : 1'b0;
      send_frame(d, 1'b1, (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'b1, 1'b1, o);
      total++; if (o.data !== 8'h03) begin bad++; $display("FAIL parity_data[%0d]: got %h want 03", k, o.data); end
      total++; if (o.pe !== (k == 0)) begin bad++; $display("FAIL parity_err[%0d]: got %b want %b", k, o.pe, k == 0); end
      idle(32);
    end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_glitch;
    bit busy_seen = 0;
    int rises = 0;
    logic prev;
    bus.rx_ready = 1'b1;
    rx = 1'b0;
    repeat (12) begin @(negedge clk); if (busy) busy_seen = 1; end
    rx = 1'b1;
    prev = bus.rx_valid;
    repeat (120) begin
      @(negedge clk);
      if (!prev && bus.rx_valid) rises++;
      prev = bus.rx_valid;
    end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    total++; if (rises != 0) begin bad++; $display("FAIL glitch_no_frame: got %0d want 0", rises); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got %b want 0", busy); end
  endtask

  task automatic test_break;
    obs_t o;
    int rises = 0, not_busy = 0;
    logic prev;
    bus.rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, o);
    total++; if (o.rose !== 1'b1) begin bad++; $display("FAIL break_valid: got %b want 1", o.rose); end
    total++; if (o.data !== 8'h55) begin bad++; $display("FAIL break_data: got %h want 55", o.data); end
    total++; if (o.fe !== 1'b1) begin bad++; $display("FAIL break_fe: got %b want 1", o.fe); end
    prev = bus.rx_valid;
    repeat (160) begin
      @(negedge clk);
      if (!prev && bus.rx_valid) rises++;
      if (!busy) not_busy++;
      prev = bus.rx_valid;
    end
    rx = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!prev && bus.rx_valid) rises++;
      prev = bus.rx_valid;
    end
    total++; if (not_busy != 0) begin bad++; $display("FAIL break_held: got %0d idle clks want 0", not_busy); end
    total++; if (rises != 0) begin bad++; $display("FAIL break_retrigger: got %0d want 0", rises); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release: got %b want 0", busy); end
  endtask

  task automatic test_overrun;
    obs_t o;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, o);
    total++; if (o.data !== 8'h11) begin bad++; $display("FAIL ovr_first_data: got %h want 11", o.data); end
    total++; if (o.ovr != 0) begin bad++; $display("FAIL ovr_first_pulse: got %0d want 0", o.ovr); end
    idle(32);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, o);
    total++; if (o.ovr != 1) begin bad++; $display("FAIL ovr_pulse_width: got %0d want 1", o.ovr); end
    total++; if (bus.rx_data !== 8'h11) begin bad++; $display("FAIL ovr_held_data: got %h want 11", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid: got %b want 1", bus.rx_valid); end
    idle(16);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept_drop: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    logic [7:0] d7e;
    bus.rx_ready = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, o);
    idle(32);
    d7e = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d7e[i]);
    rx = d7e[3];
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1 || bus.rx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got busy=%b valid=%b want 1 1", busy, bus.rx_valid); end
    #1 reset_n = 1'b0;
    #1;
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", bus.rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if ({bus.frame_err, bus.parity_err, bus.overrun_err} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b want 000", {bus.frame_err, bus.parity_err, bus.overrun_err}); end
    repeat (5) @(negedge clk);
    rx = 1'b1;
    reset_n = 1'b1;
    bus.rx_ready = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, o);
    total++; if (o.rose !== 1'b1 || o.data !== 8'hC3) begin bad++; $display("FAIL rstmid_fresh: got rose=%b data=%h want 1 c3", o.rose, o.data); end
    idle(32);
  endtask

  task automatic test_random;
    obs_t o;
    logic [7:0] d;
    logic pen, odd, pbit, stopb, exp_pe;
    bus.rx_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      odd   = 1'($urandom);
      pbit  = good_pbit(d, odd) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 7) != 0);
      exp_pe = pen && (pbit != good_pbit(d, odd));
      parity_en = pen; parity_odd = odd;
      send_frame(d, pen, pbit, stopb, o);
      total++; if (o.rose !== 1'b1) begin bad++; $display("FAIL rand_valid[%0d]: got %b want 1", n, o.rose); end
      total++; if (o.data !== d) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, o.data, d); end
      total++; if (o.fe !== ~stopb) begin bad++; $display("FAIL rand_fe[%0d]: got %b want %b", n, o.fe, ~stopb); end
      total++; if (o.pe !== exp_pe) begin bad++; $display("FAIL rand_pe[%0d]: got %b want %b", n, o.pe, exp_pe); end
      idle(32);
    end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive deserializer, directly downstream of the 16x oversampling baud tick generator.
- Consumes the 1-cycle `tick` pulse and the asynchronous `rx` line.
- Detects, samples and checks 8N1/8E1/8O1 frames.
- Delivers each byte through a one-entry valid/ready holding register to the bus/FIFO side.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..8), LSB first.
- SYNC_STAGES, 2, flops in the rx metastability synchronizer (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  16x oversampling pulse, one clk wide.
- rx  in  1  serial input, idle high, asynchronous.
- parity_en  in  1  1 = parity bit expected after data.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- overrun_err  out  1  one-clk pulse: frame completed while holding register full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - rx synchronizer flops = 1, state = IDLE, all counters = 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0, busy = 0.
- Reset mid-frame aborts immediately: partial data is discarded and rx_valid is cleared.
- rx_s = synchronized rx. All decisions use rx_s only.
- 4-bit tick counter cnt:
  - Increments only on tick while not IDLE.
  - Wraps 15->0; the wrap marks a bit boundary.
  - The sample point is cnt==7 on tick.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rx_s==0 on any clk -> START, cnt=0, bit index=0.
  - Ticks are ignored.
- START:
  - At the sample point: rx_s==1 -> IDLE (glitch rejected, nothing reported).
  - Otherwise stay in START until wrap, then -> DATA.
- DATA:
  - At the sample point, shift rx_s into shift_reg MSB side (LSB-first reception).
  - On wrap: if index==DATA_BITS-1 -> PARITY when parity_en, else STOP; otherwise index++.
- PARITY:
  - At the sample point, compute perr = (^shift_reg ^ rx_s) != parity_odd.
  - On wrap -> STOP.
- STOP:
  - At the sample point, complete the frame without waiting out the stop bit.
  - If rx_valid==0 or (rx_valid && rx_ready) in the same clk: load rx_data, set frame_err=~rx_s, set parity_err=perr (0 if parity_en=0), set rx_valid=1 on the next clk edge.
  - Otherwise drop the frame, pulse overrun_err for 1 clk, and leave the held byte and flags unchanged.
  - Next state: rx_s==1 -> IDLE; rx_s==0 -> BREAK.
- BREAK: wait for rx_s==1 -> IDLE. This prevents a line break from retriggering frames.
- Handshake:
  - rx_valid drops on the clk after rx_valid && rx_ready unless a new frame loads on that same clk.
  - A simultaneous accept and load leaves rx_valid high with the new data.
  - rx_data and the error flags are stable while rx_valid=1.
- Latency: rx_valid rises 1 clk after the stop-bit sample tick.
- parity_en and parity_odd are sampled continuously. Software changes them only while busy=0.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined:
  - Each bit (start, data, parity, stop) is the majority of rx_s captured on ticks with cnt==6, 7 and 8.
  - The decision and all sample-point actions move to cnt==8.
  - A start glitch shorter than 2 of the 3 samples is rejected.
- Undefined: single sample at cnt==7, as described above.
- Latency from stop-bit centre grows by 1 tick period when defined.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - OVERSAMPLE=16, SAMPLE_POINT=7.
  - Shared parity function, reused by the TX side.
- One natural sub-module: sync_2ff (parameterized depth, reset value 1) for rx.
- The FSM and datapath stay in uart_rx.

Test Plan:
1. Tick every 4 clks, no parity, send 0xA5 with stop=1 -> rx_valid rises 1 clk after the stop sample; rx_data=0xA5; frame_err=0; parity_err=0.
2. parity_en=1, parity_odd=0, send 0x03 with parity bit 1 (wrong) -> rx_data=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0.
3. Low pulse of 3 ticks on idle line -> rejected in START; no rx_valid; busy back to 0.
4. Send 0x55 with stop=0, then hold rx low for 40 ticks -> one frame with frame_err=1; state stays BREAK; no second frame until rx returns high.
5. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11; overrun_err pulses exactly 1 clk at the 0x22 stop sample. Then rx_ready=1 -> rx_valid drops next clk.
6. Assert reset_n=0 mid-DATA of 0x7E -> all outputs return to reset values immediately. After release, a fresh 0xC3 frame is received correctly.
